// File: rtl/chip8_timing_pkg.sv
`default_nettype none
//==============================================================================
// Module      : chip8_timing_pkg
// Description : Shared constants, reset-sequencer state type and the phase
//               increment helper for the Chip-8 timing generator.
// Revision    : 1.0 - initial release
//==============================================================================
package chip8_timing_pkg;

    localparam int ACC_W_DEF = 32;

    // Bit positions inside rst_cause and the event vectors
    localparam int CAUSE_DL  = 0;
    localparam int CAUSE_BTN = 1;
    localparam int CAUSE_ERR = 2;
    localparam int CAUSE_W   = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        STRETCH = 1'b1
    } rst_state_t;

    // round(f_hz * 2^ACC_W / clk_hz); evaluated at elaboration or in benches
    function automatic logic [ACC_W_DEF-1:0] calc_inc(
        input longint unsigned clk_hz,
        input longint unsigned f_hz
    );
        longint unsigned num;
        longint unsigned quo;
        num = (f_hz << ACC_W_DEF) + (clk_hz >> 1);
        quo = num / clk_hz;
        return quo[ACC_W_DEF-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_frac_ce.sv
`default_nettype none
//==============================================================================
// Module      : chip8_frac_ce
// Description : One phase-accumulator channel: carry-out becomes a one-cycle
//               clock enable, accumulator MSB becomes a square wave.
// Revision    : 1.0 - initial release
//==============================================================================
module chip8_frac_ce #(
    parameter int ACC_W = 32
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_ce,
    output logic             o_sq
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ce_q;
    logic             ce_d;
    logic             sq_q;
    logic             sq_d;
    logic [ACC_W:0]   w_sum;

    // The accumulator is never cleared on an increment change, only on disable,
    // so retuning a running channel keeps its phase.
    always_comb begin
        w_sum = {1'b0, acc_q} + {1'b0, i_inc};
        acc_d = '0;
        ce_d  = 1'b0;
        sq_d  = 1'b0;
        if (i_en) begin
            acc_d = w_sum[ACC_W-1:0];
            ce_d  = w_sum[ACC_W];
            sq_d  = w_sum[ACC_W-1];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
            sq_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
            sq_q  <= sq_d;
        end
    end

    assign o_ce = ce_q;
    assign o_sq = sq_q;

endmodule
`default_nettype wire

// File: rtl/chip8_timing_gen.sv
`default_nettype none
//==============================================================================
// Module      : chip8_timing_gen
// Description : Multi-channel fractional clock-enable generator plus a
//               retriggerable machine-reset sequencer for the Chip-8 core.
// Revision    : 1.0 - initial release
//==============================================================================
module chip8_timing_gen
    import chip8_timing_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int RST_CH     = 1,
    parameter int RST_CYCLES = 16,
    parameter int HOLD_DL    = 1
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*ACC_W-1:0] ch_inc,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       sq_out,
    input  logic                    dl_active,
    input  logic                    btn,
    input  logic                    err,
    output logic                    rst_out,
    output logic [CAUSE_W-1:0]      rst_cause
);

    localparam int             CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

    //--------------------------------------------------------------------------
    // Clock-enable channels
    //--------------------------------------------------------------------------
    logic [NUM_CH-1:0] w_ce;
    logic [NUM_CH-1:0] w_sq;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            chip8_frac_ce #(
                .ACC_W (ACC_W)
            ) u_ce (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .i_en    (ch_en[gi]),
                .i_inc   (ch_inc[gi*ACC_W +: ACC_W]),
                .o_ce    (w_ce[gi]),
                .o_sq    (w_sq[gi])
            );
        end
    endgenerate

    assign ce_out = w_ce;
    assign sq_out = w_sq;

    //--------------------------------------------------------------------------
    // Event synchronisers and edge detect, indexed by the CAUSE_* constants
    //--------------------------------------------------------------------------
    logic [CAUSE_W-1:0] w_ev_async;
    logic [CAUSE_W-1:0] sync1_q;
    logic [CAUSE_W-1:0] sync2_q;
    logic [CAUSE_W-1:0] prev_q;
    logic [CAUSE_W-1:0] w_trig;
    logic               w_any_trig;
    logic               w_tick;

    always_comb begin
        w_ev_async            = '0;
        w_ev_async[CAUSE_DL]  = dl_active;
        w_ev_async[CAUSE_BTN] = btn;
        w_ev_async[CAUSE_ERR] = err;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= w_ev_async;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Download end is the falling edge; button and error fire on rising edges
    always_comb begin
        w_trig            = '0;
        w_trig[CAUSE_DL]  = prev_q[CAUSE_DL] & ~sync2_q[CAUSE_DL];
        w_trig[CAUSE_BTN] = sync2_q[CAUSE_BTN] & ~prev_q[CAUSE_BTN];
        w_trig[CAUSE_ERR] = sync2_q[CAUSE_ERR] & ~prev_q[CAUSE_ERR];
        w_any_trig        = |w_trig;
    end

    assign w_tick = w_ce[RST_CH];

    //--------------------------------------------------------------------------
    // Reset sequencer
    //--------------------------------------------------------------------------
    rst_state_t         state_q;
    rst_state_t         state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_d;
    logic               rst_out_q;
    logic               rst_out_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (w_any_trig) begin
                    state_d = STRETCH;
                    count_d = '0;
                    cause_d = w_trig;
                end
            end
            STRETCH: begin
                // A retrigger wins over a coincident tick so the restart is clean
                if (w_any_trig) begin
                    count_d = '0;
                    cause_d = cause_q | w_trig;
                end else if ((HOLD_DL != 0) && sync2_q[CAUSE_DL]) begin
                    count_d = '0;
                end else if (w_tick) begin
                    if (count_q == CNT_LAST) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        rst_out_d = (state_d == STRETCH);
    end

    // Power-up enters STRETCH so the machine sees a full reset after release
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STRETCH;
            count_q   <= '0;
            cause_q   <= '0;
            rst_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cause_q   <= cause_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign rst_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_timing_gen.sv
`default_nettype none
//==============================================================================
// Module      : tb_chip8_timing_gen
// Description : Directed self-checking bench for chip8_timing_gen.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_chip8_timing_gen;
    import chip8_timing_pkg::*;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 32;
    localparam int RST_CH = 1;

    logic                    clk_sys = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*ACC_W-1:0] ch_inc;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH-1:0]       sq_out;
    logic                    dl_active;
    logic                    btn;
    logic                    err;
    logic                    rst_out;
    logic [2:0]              rst_cause;

    int n_cmp = 0;
    int n_bad = 0;

    chip8_timing_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .RST_CH     (RST_CH),
        .RST_CYCLES (16),
        .HOLD_DL    (1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ch_en     (ch_en),
        .ch_inc    (ch_inc),
        .ce_out    (ce_out),
        .sq_out    (sq_out),
        .dl_active (dl_active),
        .btn       (btn),
        .err       (err),
        .rst_out   (rst_out),
        .rst_cause (rst_cause)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_inc(input int ch, input logic [ACC_W-1:0] v);
        ch_inc[ch*ACC_W +: ACC_W] = v;
    endtask

    // Counts samples with rst_out high and an RST_CH tick pending, until rst_out drops
    task automatic measure_stretch(output int ticks, output bit timed_out);
        ticks     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!rst_out) begin
                timed_out = 1'b0;
                break;
            end
            if (ce_out[RST_CH]) ticks++;
            tick();
        end
    endtask

    task automatic wait_rise(output int lat, output bit timed_out);
        lat       = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (rst_out) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        ch_en     = 3'b010;
        ch_inc    = '0;
        set_inc(1, 32'hFFFF_FFFF);
        dl_active = 1'b0;
        btn       = 1'b0;
        err       = 1'b0;
        repeat (3) tick();
        n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL reset_ce: got %b expected 000", ce_out); end
        n_cmp++; if (sq_out !== 3'b000) begin n_bad++; $display("FAIL reset_sq: got %b expected 000", sq_out); end
        n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL reset_rst_out: got %b expected 1", rst_out); end
        n_cmp++; if (rst_cause !== 3'b000) begin n_bad++; $display("FAIL reset_cause: got %b expected 000", rst_cause); end
        reset_n = 1'b1;
    endtask

    task automatic test_powerup_stretch();
        int ticks; bit to;
        measure_stretch(ticks, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL powerup_end: stretch did not end, got timeout=%b expected 0", to); end
        n_cmp++; if (ticks != 16) begin n_bad++; $display("FAIL powerup_ticks: got %0d expected 16", ticks); end
        n_cmp++; if (rst_cause !== 3'b000) begin n_bad++; $display("FAIL powerup_cause: got %b expected 000", rst_cause); end
    endtask

    task automatic test_calc_inc();
        logic [31:0] v;
        v = calc_inc(64'd50_000_000, 64'd12000);
        n_cmp++; if (v !== 32'd1030792) begin n_bad++; $display("FAIL calc_inc_12k: got %0d expected 1030792", v); end
        v = calc_inc(64'd50_000_000, 64'd60);
        n_cmp++; if (v !== 32'd5154) begin n_bad++; $display("FAIL calc_inc_60: got %0d expected 5154", v); end
    endtask

    // inc = 2^30: acc walks 4000_0000, 8000_0000, C000_0000, 0 (carry)
    task automatic test_ce_pattern();
        logic [7:0] ce_h; logic [7:0] sq_h;
        ch_en[0] = 1'b0; tick();
        set_inc(0, 32'h4000_0000);
        ch_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            ce_h[k] = ce_out[0];
            sq_h[k] = sq_out[0];
        end
        n_cmp++; if (ce_h !== 8'h88) begin n_bad++; $display("FAIL ce_pattern: got %h expected 88", ce_h); end
        n_cmp++; if (sq_h !== 8'h66) begin n_bad++; $display("FAIL sq_pattern: got %h expected 66", sq_h); end
    endtask

    task automatic test_disable_reenable();
        logic ce_any; int first;
        tick(); tick();
        n_cmp++; if (sq_out[0] !== 1'b1) begin n_bad++; $display("FAIL pre_disable_sq: got %b expected 1", sq_out[0]); end
        ch_en[0] = 1'b0;
        tick();
        n_cmp++; if ({ce_out[0], sq_out[0]} !== 2'b00) begin n_bad++; $display("FAIL disable_next: got %b expected 00", {ce_out[0], sq_out[0]}); end
        ce_any = 1'b0;
        repeat (6) begin tick(); ce_any = ce_any | ce_out[0] | sq_out[0]; end
        n_cmp++; if (ce_any !== 1'b0) begin n_bad++; $display("FAIL disable_quiet: got %b expected 0", ce_any); end
        ch_en[0] = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ce_out[0] && first == 0) first = k;
        end
        n_cmp++; if (first != 4) begin n_bad++; $display("FAIL reenable_first: got %0d expected 4", first); end
    endtask

    // Retune 2^30 -> 2^31 after one add: 4000_0000 -> C000_0000 -> 4000_0000+carry
    task automatic test_inc_change();
        ch_en[0] = 1'b0; tick();
        set_inc(0, 32'h4000_0000);
        ch_en[0] = 1'b1;
        tick();
        set_inc(0, 32'h8000_0000);
        tick();
        n_cmp++; if ({ce_out[0], sq_out[0]} !== 2'b01) begin n_bad++; $display("FAIL inc_change_1: got %b expected 01", {ce_out[0], sq_out[0]}); end
        tick();
        n_cmp++; if ({ce_out[0], sq_out[0]} !== 2'b10) begin n_bad++; $display("FAIL inc_change_2: got %b expected 10", {ce_out[0], sq_out[0]}); end
        ch_en[0] = 1'b0;
    endtask

    task automatic test_inc_zero();
        logic ce_any; logic sq_all;
        ch_en[2] = 1'b0; tick();
        set_inc(2, 32'h8000_0000);
        ch_en[2] = 1'b1;
        tick();
        set_inc(2, 32'h0);
        ce_any = 1'b0; sq_all = 1'b1;
        repeat (8) begin tick(); ce_any = ce_any | ce_out[2]; sq_all = sq_all & sq_out[2]; end
        n_cmp++; if ({ce_any, sq_all} !== 2'b01) begin n_bad++; $display("FAIL inc_zero: got ce_any,sq_all=%b expected 01", {ce_any, sq_all}); end
    endtask

    // inc = 0x66666666 (just under 0.4): pulses at 3,6,8,11,... -> 19 in 50 cycles
    task automatic test_fractional();
        int cnt; int last; int gmin; int gmax;
        ch_en[2] = 1'b0; tick();
        set_inc(2, 32'h6666_6666);
        ch_en[2] = 1'b1;
        cnt = 0; last = 0; gmin = 1000; gmax = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (ce_out[2]) begin
                cnt++;
                if (k - last < gmin) gmin = k - last;
                if (k - last > gmax) gmax = k - last;
                last = k;
            end
        end
        n_cmp++; if (cnt != 19) begin n_bad++; $display("FAIL frac_count: got %0d expected 19", cnt); end
        n_cmp++; if (gmin != 2 || gmax != 3) begin n_bad++; $display("FAIL frac_gaps: got %0d..%0d expected 2..3", gmin, gmax); end
    endtask

    // 12 kHz from 50 MHz: carries after 4167, 8334 and 12501 adds
    task automatic test_rate_12k();
        int cnt; int pos[3];
        ch_en[2] = 1'b0; tick();
        set_inc(2, calc_inc(64'd50_000_000, 64'd12000));
        ch_en[2] = 1'b1;
        cnt = 0; pos[0] = 0; pos[1] = 0; pos[2] = 0;
        for (int k = 1; k <= 12600; k++) begin
            tick();
            if (ce_out[2]) begin
                if (cnt < 3) pos[cnt] = k;
                cnt++;
            end
        end
        n_cmp++; if (cnt != 3) begin n_bad++; $display("FAIL rate12k_count: got %0d expected 3", cnt); end
        n_cmp++; if (pos[0] != 4167 || pos[1] != 8334 || pos[2] != 12501) begin
            n_bad++; $display("FAIL rate12k_pos: got %0d,%0d,%0d expected 4167,8334,12501", pos[0], pos[1], pos[2]);
        end
        ch_en[2] = 1'b0;
        tick();
    endtask

    task automatic test_dl_trigger();
        int lat; bit to; int ticks;
        dl_active = 1'b1;
        repeat (5) tick();
        n_cmp++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL dl_rise_no_trig: got %b expected 0", rst_out); end
        dl_active = 1'b0;
        wait_rise(lat, to);
        n_cmp++; if (to || lat > 4) begin n_bad++; $display("FAIL dl_latency: got %0d (timeout=%b) expected <=4", lat, to); end
        n_cmp++; if (rst_cause !== 3'b001) begin n_bad++; $display("FAIL dl_cause: got %b expected 001", rst_cause); end
        measure_stretch(ticks, to);
        n_cmp++; if (to || ticks != 16) begin n_bad++; $display("FAIL dl_ticks: got %0d (timeout=%b) expected 16", ticks, to); end
    endtask

    task automatic test_hold_dl();
        int lat; bit to; int ticks; logic all_high;
        btn = 1'b1;
        wait_rise(lat, to);
        n_cmp++; if (to || rst_cause !== 3'b010) begin n_bad++; $display("FAIL hold_btn_cause: got %b (timeout=%b) expected 010", rst_cause, to); end
        dl_active = 1'b1;
        btn       = 1'b0;
        all_high  = 1'b1;
        repeat (40) begin tick(); all_high = all_high & rst_out; end
        n_cmp++; if (all_high !== 1'b1) begin n_bad++; $display("FAIL hold_dl_high: got %b expected 1", all_high); end
        // Two held samples while the fall synchronises, the trigger sample, then 16
        dl_active = 1'b0;
        measure_stretch(ticks, to);
        n_cmp++; if (to || ticks != 19) begin n_bad++; $display("FAIL hold_release_ticks: got %0d (timeout=%b) expected 19", ticks, to); end
        n_cmp++; if (rst_cause !== 3'b011) begin n_bad++; $display("FAIL hold_cause: got %b expected 011", rst_cause); end
    endtask

    // btn raised after tick 8 lands on tick 10 after the synchroniser
    task automatic test_retrigger();
        int lat; bit to; int ticks; bit raised;
        dl_active = 1'b1;
        repeat (4) tick();
        dl_active = 1'b0;
        wait_rise(lat, to);
        ticks = 0; raised = 1'b0; to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!rst_out) begin to = 1'b0; break; end
            if (ce_out[RST_CH]) ticks++;
            if (ticks == 8 && !raised) begin btn = 1'b1; raised = 1'b1; end
            tick();
        end
        n_cmp++; if (to || ticks != 26) begin n_bad++; $display("FAIL retrig_ticks: got %0d (timeout=%b) expected 26", ticks, to); end
        n_cmp++; if (rst_cause !== 3'b011) begin n_bad++; $display("FAIL retrig_cause: got %b expected 011", rst_cause); end
        btn = 1'b0;
        repeat (4) tick();
        n_cmp++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL btn_fall_no_trig: got %b expected 0", rst_out); end
    endtask

    task automatic test_simultaneous();
        int lat; bit to; int ticks;
        btn = 1'b1;
        err = 1'b1;
        wait_rise(lat, to);
        n_cmp++; if (to || rst_cause !== 3'b110) begin n_bad++; $display("FAIL simul_cause: got %b (timeout=%b) expected 110", rst_cause, to); end
        measure_stretch(ticks, to);
        n_cmp++; if (to || ticks != 16) begin n_bad++; $display("FAIL simul_ticks: got %0d (timeout=%b) expected 16", ticks, to); end
        btn = 1'b0;
        err = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_stretch();
        int lat; bit to; int ticks;
        btn = 1'b1;
        wait_rise(lat, to);
        n_cmp++; if (to || rst_cause !== 3'b010) begin n_bad++; $display("FAIL mid_btn_cause: got %b (timeout=%b) expected 010", rst_cause, to); end
        btn = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({rst_out, rst_cause, ce_out} !== 7'b1_000_000) begin
            n_bad++; $display("FAIL mid_reset_async: got rst=%b cause=%b ce=%b expected 1/000/000", rst_out, rst_cause, ce_out);
        end
        tick();
        reset_n = 1'b1;
        measure_stretch(ticks, to);
        n_cmp++; if (to || ticks != 16) begin n_bad++; $display("FAIL mid_restart_ticks: got %0d (timeout=%b) expected 16", ticks, to); end
        n_cmp++; if (rst_cause !== 3'b000) begin n_bad++; $display("FAIL mid_restart_cause: got %b expected 000", rst_cause); end
    endtask

    initial begin
        test_reset();
        test_powerup_stretch();
        test_calc_inc();
        test_ce_pattern();
        test_disable_reenable();
        test_inc_change();
        test_inc_zero();
        test_fractional();
        test_rate_12k();
        test_dl_trigger();
        test_hold_dl();
        test_retrigger();
        test_simultaneous();
        test_reset_mid_stretch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
